stopwatch_ctrl: RTL and testbench

Stopwatch run/lap/clear controller that owns the stopwatch time base and sequences the six BCD digits feeding the multiplexed 7-segment display scanner. It divides the system clock down to a 1/100 s tick, counts MM:SS.cc in BCD, and services two pre-debounced push-button pulses: start/stop and lap/clear. Lap mode freezes the displayed value while counting continues underneath.

---
 rtl/stopwatch_pkg.sv | 25 ++
 rtl/stopwatch_if.sv | 21 ++
 rtl/bcd_digit_cnt.sv | 27 ++
 rtl/stopwatch_ctrl.sv | 100 ++++++++++
 tb/tb_stopwatch_ctrl.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the stopwatch controller: FSM states, BCD digit type,
// per-digit limits and the BCD increment function used by both counter and snapshot path.
package stopwatch_pkg;

  typedef enum logic [1:0] {IDLE, RUN, LAP, PAUSE} sw_state_e;

  typedef logic [3:0] bcd_t;

  localparam bcd_t DIG_MAX_9  = 4'd9;
  localparam bcd_t DIG_MAX_5  = 4'd5;
  localparam int   NUM_DIGITS = 6;

  // Digit order: 0=cs_lo 1=cs_hi 2=s_lo 3=s_hi 4=m_lo 5=m_hi
  function automatic bcd_t digit_max(int k);
    return (k == 3 || k == 5) ? DIG_MAX_5 : DIG_MAX_9;
  endfunction

  // Out-of-range digits fall back to 0 so a corrupted register self-heals on the next tick.
  function automatic bcd_t bcd_next(bcd_t q, bcd_t max, logic inc);
    if (!inc)          return q;
    else if (q >= max) return '0;
    else               return q + 4'd1;
  endfunction

endpackage

// File: rtl/stopwatch_if.sv
// Key inputs and display/status outputs of the stopwatch controller.
interface stopwatch_if;
  import stopwatch_pkg::*;

  logic key_ss;
  logic key_lap;
  bcd_t cs_lo, cs_hi, s_lo, s_hi, m_lo, m_hi;
  logic running;
  logic lap_active;
  logic wrap;

  modport master (
    output key_ss, key_lap,
    input  cs_lo, cs_hi, s_lo, s_hi, m_lo, m_hi, running, lap_active, wrap
  );

  modport slave (
    input  key_ss, key_lap,
    output cs_lo, cs_hi, s_lo, s_hi, m_lo, m_hi, running, lap_active, wrap
  );
endinterface

// File: rtl/bcd_digit_cnt.sv
// One BCD digit of the time chain; carry fires when an increment hits MAX.
module bcd_digit_cnt
  import stopwatch_pkg::*;
#(
  parameter bcd_t MAX = DIG_MAX_9
) (
  input  logic fs,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output bcd_t q,
  output logic carry
);

  bcd_t q_q, q_d;

  always_comb q_d = clr ? '0 : bcd_next(q_q, MAX, inc);

  always_ff @(posedge fs or negedge rst_n) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q     = q_q;
  assign carry = inc && (q_q == MAX);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch run/lap/clear controller: 1/100 s prescaler, six-digit BCD chain,
// lap snapshot and the display mux feeding the 7-segment scanner.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int CLK_DIV = 500000
) (
  input  logic        fs,
  input  logic        rst_n,
  stopwatch_if.slave  sw
);

  localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

  sw_state_e state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  bcd_t [NUM_DIGITS-1:0] live, live_nxt, snap_q, snap_d, disp;
  logic [NUM_DIGITS-1:0] inc, carry;
  logic counting, tick, clr, snap_ld;
  logic wrap_q, wrap_d;

  // key_ss is evaluated first in every state so it wins over a simultaneous key_lap
  always_comb begin
    state_d = state_q;
    clr     = 1'b0;
    snap_ld = 1'b0;
    unique case (state_q)
      IDLE:  if (sw.key_ss) state_d = RUN;
      RUN:   if (sw.key_ss) state_d = PAUSE;
             else if (sw.key_lap) begin state_d = LAP; snap_ld = 1'b1; end
      LAP:   if (sw.key_ss) state_d = PAUSE;
             else if (sw.key_lap) state_d = RUN;
      PAUSE: if (sw.key_ss) state_d = RUN;
             else if (sw.key_lap) begin state_d = IDLE; clr = 1'b1; end
      default: state_d = IDLE;
    endcase
  end

  assign counting = (state_q == RUN) || (state_q == LAP);
  assign tick     = counting && (presc_q == PRESC_LAST);

  // Outside RUN/LAP the prescaler holds, keeping the partial tick across a pause
  always_comb begin
    presc_d = presc_q;
    if (clr)           presc_d = '0;
    else if (tick)     presc_d = '0;
    else if (counting) presc_d = presc_q + 1'b1;
  end

  assign inc = {carry[NUM_DIGITS-2:0], tick};

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dig
    bcd_digit_cnt #(.MAX(digit_max(k))) u_dig (
      .fs    (fs),
      .rst_n (rst_n),
      .inc   (inc[k]),
      .clr   (clr),
      .q     (live[k]),
      .carry (carry[k])
    );
    // Mirrors the digit's next value so a lap snapshot includes a same-edge increment
    assign live_nxt[k] = clr ? '0 : bcd_next(live[k], digit_max(k), inc[k]);
  end

  always_comb begin
    snap_d = snap_q;
    if (snap_ld)  snap_d = live_nxt;
    else if (clr) snap_d = '0;
  end

  assign wrap_d = carry[NUM_DIGITS-1];

  always_ff @(posedge fs or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      presc_q <= '0;
      snap_q  <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      snap_q  <= snap_d;
      wrap_q  <= wrap_d;
    end
  end

  assign disp = (state_q == LAP) ? snap_q : live;

  assign sw.cs_lo      = disp[0];
  assign sw.cs_hi      = disp[1];
  assign sw.s_lo       = disp[2];
  assign sw.s_hi       = disp[3];
  assign sw.m_lo       = disp[4];
  assign sw.m_hi       = disp[5];
  assign sw.running    = counting;
  assign sw.lap_active = (state_q == LAP);
  assign sw.wrap       = wrap_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl with CLK_DIV=4: stimulus schedules expected
// outputs per clock edge, a monitor compares them once that edge has passed.
module tb_stopwatch_ctrl;
  import stopwatch_pkg::*;

  localparam int CLK_DIV = 4;

  logic fs = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_run = 0;
  int   n_fail = 0;

  stopwatch_if sw_if ();

  stopwatch_ctrl #(.CLK_DIV(CLK_DIV)) dut (
    .fs    (fs),
    .rst_n (rst_n),
    .sw    (sw_if)
  );

  always #5 fs = ~fs;
  always @(posedge fs) cyc <= cyc + 1;

  typedef struct {
    string       name;
    int          cyc;
    logic [23:0] disp;   // {m_hi,m_lo,s_hi,s_lo,cs_hi,cs_lo}
    logic        run;
    logic        lap;
    logic        wrap;
  } exp_t;

  exp_t sb[$];

  task automatic expect_at(input int c, input string nm, input logic [23:0] d,
                           input logic r, input logic l, input logic w);
    exp_t e;
    e.name = nm; e.cyc = c; e.disp = d; e.run = r; e.lap = l; e.wrap = w;
    sb.push_back(e);
  endtask

  // Monitor: entries due at the current edge count are compared 2 time units after the negedge.
  always begin
    @(negedge fs);
    #2;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        logic [23:0] got;
        got = {sw_if.m_hi, sw_if.m_lo, sw_if.s_hi, sw_if.s_lo, sw_if.cs_hi, sw_if.cs_lo};
        n_run++;
        if (sb[i].cyc != cyc || got !== sb[i].disp || sw_if.running !== sb[i].run ||
            sw_if.lap_active !== sb[i].lap || sw_if.wrap !== sb[i].wrap) begin
          n_fail++;
          $display("FAIL %s @%0d (due %0d): got disp=%h run=%b lap=%b wrap=%b, expected disp=%h run=%b lap=%b wrap=%b",
                   sb[i].name, cyc, sb[i].cyc, got, sw_if.running, sw_if.lap_active, sw_if.wrap,
                   sb[i].disp, sb[i].run, sb[i].lap, sb[i].wrap);
        end
        sb.delete(i);
      end
    end
  end

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge fs);
  endtask

  // Key pulse accepted at rising edge number e.
  task automatic press(input logic ss, input logic lap, input int e);
    wait_to(e - 1);
    sw_if.key_ss  = ss;
    sw_if.key_lap = lap;
    @(negedge fs);
    sw_if.key_ss  = 1'b0;
    sw_if.key_lap = 1'b0;
  endtask

  int b;

  initial begin
    sw_if.key_ss  = 1'b0;
    sw_if.key_lap = 1'b0;
    expect_at(2, "reset_state", 24'h000000, 0, 0, 0);
    @(negedge fs);
    wait_to(4);
    rst_n = 1'b1;
    b = 8;

    // start from IDLE, ticks every 4 edges, carry into seconds
    expect_at(b,       "run_on",      24'h000000, 1, 0, 0);
    expect_at(b + 3,   "pre_tick1",   24'h000000, 1, 0, 0);
    expect_at(b + 4,   "tick1",       24'h000001, 1, 0, 0);
    expect_at(b + 8,   "tick2",       24'h000002, 1, 0, 0);
    expect_at(b + 396, "cs_99",       24'h000099, 1, 0, 0);
    expect_at(b + 400, "carry_to_s",  24'h000100, 1, 0, 0);
    press(1, 0, b);

    // lap on the tick edge reaching 00:01.23, hold 40 cycles, release to live 00:01.33
    expect_at(b + 491, "pre_lap",     24'h000122, 1, 0, 0);
    expect_at(b + 492, "lap_snap",    24'h000123, 1, 1, 0);
    expect_at(b + 531, "lap_hold",    24'h000123, 1, 1, 0);
    expect_at(b + 532, "lap_release", 24'h000133, 1, 0, 0);
    press(0, 1, b + 492);
    press(0, 1, b + 532);

    // pause 2 cycles past a tick, stay static, resume: tick after 2 cycles
    expect_at(b + 534, "pause",        24'h000133, 0, 0, 0);
    expect_at(b + 634, "pause_static", 24'h000133, 0, 0, 0);
    expect_at(b + 640, "resume",       24'h000133, 1, 0, 0);
    expect_at(b + 641, "resume_pre",   24'h000133, 1, 0, 0);
    expect_at(b + 642, "resume_tick",  24'h000134, 1, 0, 0);
    press(1, 0, b + 534);
    press(1, 0, b + 640);

    // both keys together in RUN: start/stop wins, tick on same edge still counts
    expect_at(b + 650, "both_keys",   24'h000136, 0, 0, 0);
    press(1, 1, b + 650);

    // clear from PAUSE, lap ignored in IDLE, prescaler restarts from 0
    expect_at(b + 655, "clear",        24'h000000, 0, 0, 0);
    expect_at(b + 661, "idle_lap",     24'h000000, 0, 0, 0);
    expect_at(b + 673, "restart_pre",  24'h000000, 1, 0, 0);
    expect_at(b + 674, "restart_tick", 24'h000001, 1, 0, 0);
    press(0, 1, b + 655);
    press(0, 1, b + 660);
    press(1, 0, b + 670);

    // pause, preload 59:59.99, resume: wrap to zero with a one-cycle wrap pulse
    expect_at(b + 676, "pause2",   24'h000001, 0, 0, 0);
    press(1, 0, b + 676);
    wait_to(b + 680);
    force dut.g_dig[0].u_dig.q_q = 4'd9;
    force dut.g_dig[1].u_dig.q_q = 4'd9;
    force dut.g_dig[2].u_dig.q_q = 4'd9;
    force dut.g_dig[3].u_dig.q_q = 4'd5;
    force dut.g_dig[4].u_dig.q_q = 4'd9;
    force dut.g_dig[5].u_dig.q_q = 4'd5;
    @(negedge fs);
    release dut.g_dig[0].u_dig.q_q;
    release dut.g_dig[1].u_dig.q_q;
    release dut.g_dig[2].u_dig.q_q;
    release dut.g_dig[3].u_dig.q_q;
    release dut.g_dig[4].u_dig.q_q;
    release dut.g_dig[5].u_dig.q_q;
    expect_at(b + 682, "preload",  24'h595999, 0, 0, 0);
    expect_at(b + 686, "pre_wrap", 24'h595999, 1, 0, 0);
    expect_at(b + 687, "wrap",     24'h000000, 1, 0, 1);
    expect_at(b + 688, "wrap_one", 24'h000000, 1, 0, 0);
    press(1, 0, b + 685);

    // asynchronous reset mid-run, checked before any further rising edge
    expect_at(b + 694, "pre_rst",   24'h000001, 1, 0, 0);
    expect_at(b + 695, "async_rst", 24'h000000, 0, 0, 0);
    wait_to(b + 695);
    rst_n = 1'b0;
    expect_at(b + 698, "rst_held",  24'h000000, 0, 0, 0);

    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge fs);
    if (sb.size() != 0) begin
      n_run++;
      n_fail++;
      $display("FAIL drain: %0d expectations never checked, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
